// File: rtl/register_file_clr.sv
// register_file_clr: WIDTH x DEPTH register file, 1 write / 2 read ports, hardwired zero, bypass and sequenced clear
module register_file_clr #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [WIDTH-1:0]  rd_data1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data2,
   input  logic              clr_start,
   output logic              busy,
   output logic              clr_done
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic we, last;
   assign busy = state == CLEAR;
   assign wr_ready = !busy;
   assign last = int'(ptr) == DEPTH - 1;
   assign we = wr_en && !busy && int'(wr_addr) < DEPTH && !(ZERO_REG != 0 && wr_addr == '0);
   assign rd_data1 = (int'(rd_addr1) >= DEPTH || (ZERO_REG != 0 && rd_addr1 == '0)) ? '0 :
                     (BYPASS != 0 && we && wr_addr == rd_addr1) ? wr_data : mem[rd_addr1];
   assign rd_data2 = (int'(rd_addr2) >= DEPTH || (ZERO_REG != 0 && rd_addr2 == '0)) ? '0 :
                     (BYPASS != 0 && we && wr_addr == rd_addr2) ? wr_data : mem[rd_addr2];
   always_comb begin
      state_n = busy ? (last ? IDLE : CLEAR) : (clr_start ? CLEAR : IDLE);
      ptr_n = (busy && !last) ? ptr + 1'b1 : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         state <= IDLE;
         ptr <= '0;
         clr_done <= 1'b0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         clr_done <= busy && last;
         if (we) mem[wr_addr] <= wr_data;
         if (busy) mem[ptr] <= '0;
      end
   end
endmodule
